ddp_elastic_pipe8: RTL and testbench

Eight-stage synchronous elastic data pipeline for the data-driven processor datapath, consuming packets under a Send/Ack handshake and advancing them stage by stage. It is the downstream consumer of the eight-phase stage-strobe ring. It reproduces the self-timed Send/Ack stage protocol in one clock domain. It emits a per-stage capture strobe CP[i], bit-compatible with the ring's CP1..CP8 outputs, so downstream latch and debug logic can use either source.

---
 rtl/ddp_elastic_pipe8.sv | 96 +++++++++
 tb/tb_ddp_elastic_pipe8.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/ddp_elastic_pipe8.sv
// Eight-stage elastic Send/Ack pipeline in a single clock domain.
// Packets advance whenever the next stage is empty or emptying in the same cycle.
module ddp_elastic_pipe8 #(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             MR,
  input  logic             Send_in,
  input  logic [WIDTH-1:0] Data_in,
  output logic             Ack_out,
  output logic             Send_out,
  output logic [WIDTH-1:0] Data_out,
  input  logic             Ack_in,
  output logic [7:0]       CP,
  output logic [3:0]       Occupancy
);

  // Handshake: a packet moves across a boundary on a rising edge only when
  // the sender's Send and the receiver's Ack are both high during that cycle;
  // the sender holds Send/Data stable until it sees Ack.

  logic [7:0]       full_q;
  logic [7:0]       full_d;
  logic [WIDTH-1:0] data_q [8];
  logic [7:0]       cp_q;
  logic [3:0]       occ_q;
  logic [3:0]       occ_d;

  logic [8:0] free;
  logic [8:1] go;
  logic [7:0] load;
  logic       xin;
  logic       xout;

  // Free/go chain runs from the output stage back to the input stage, so
  // Ack_in ripples combinationally all the way to Ack_out.
  always_comb begin
    free    = '0;
    go      = '0;
    free[8] = Ack_in;
    for (int i = 7; i >= 0; i--) begin
      go[i+1] = full_q[i] & free[i+1];
      free[i] = ~full_q[i] | go[i+1];
    end
  end

  assign Ack_out = free[0] & ~MR;
  assign xin     = Send_in & Ack_out;
  assign xout    = full_q[7] & Ack_in;

  always_comb begin
    load    = '0;
    full_d  = '0;
    load[0] = xin;
    for (int i = 1; i < 8; i++) begin
      load[i] = go[i];
    end
    for (int i = 0; i < 8; i++) begin
      full_d[i] = load[i] | (full_q[i] & ~go[i+1]);
    end
  end

  always_comb begin
    occ_d = occ_q;
    case ({xin, xout})
      2'b10:   occ_d = occ_q + 4'd1;
      2'b01:   occ_d = occ_q - 4'd1;
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (MR) begin
      full_q <= '0;
      cp_q   <= '0;
      occ_q  <= '0;
      for (int i = 0; i < 8; i++) begin
        data_q[i] <= '0;
      end
    end else begin
      full_q <= full_d;
      cp_q   <= load;
      occ_q  <= occ_d;
      if (load[0]) data_q[0] <= Data_in;
      for (int i = 1; i < 8; i++) begin
        if (load[i]) data_q[i] <= data_q[i-1];
      end
    end
  end

  assign Send_out  = full_q[7];
  assign Data_out  = data_q[7];
  assign CP        = cp_q;
  assign Occupancy = occ_q;

endmodule

// File: tb/tb_ddp_elastic_pipe8.sv
// Directed bench for ddp_elastic_pipe8: reset, latency, streaming,
// backpressure, bubble collapse and mid-flight reset, with an ordering scoreboard.
module tb_ddp_elastic_pipe8;

  localparam int W = 32;

  logic         CLK;
  logic         MR;
  logic         Send_in;
  logic [W-1:0] Data_in;
  logic         Ack_out;
  logic         Send_out;
  logic [W-1:0] Data_out;
  logic         Ack_in;
  logic [7:0]   CP;
  logic [3:0]   Occupancy;

  int n_checks = 0;
  int n_errors = 0;
  int out_cnt  = 0;

  logic [W-1:0] exp_q[$];

  ddp_elastic_pipe8 #(.WIDTH(W)) dut (
    .CLK      (CLK),
    .MR       (MR),
    .Send_in  (Send_in),
    .Data_in  (Data_in),
    .Ack_out  (Ack_out),
    .Send_out (Send_out),
    .Data_out (Data_out),
    .Ack_in   (Ack_in),
    .CP       (CP),
    .Occupancy(Occupancy)
  );

  // clock / reset block
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // advance one edge; inputs are driven 1 time unit after the edge
  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  // scoreboard: sampled mid-cycle, away from the active edge
  always @(negedge CLK) begin
    if (MR) begin
      exp_q.delete();
    end else begin
      if (Send_out && Ack_in) begin
        chk("out_pending", (exp_q.size() != 0) ? 32'd1 : 32'd0, 32'd1);
        if (exp_q.size() != 0) chk("out_data", Data_out, exp_q.pop_front());
        out_cnt++;
      end
      if (Send_in && Ack_out) exp_q.push_back(Data_in);
    end
  end

  initial begin
    MR      = 1'b1;
    Send_in = 1'b1;
    Data_in = 32'hDEAD_0000;
    Ack_in  = 1'b0;
    #1;
    chk("ack_in_mr_pre", {31'd0, Ack_out}, 32'd0);

    // reset for two cycles with Send_in high
    cyc();
    chk("rst_ack",  {31'd0, Ack_out}, 32'd0);
    chk("rst_send", {31'd0, Send_out}, 32'd0);
    chk("rst_data", Data_out, 32'd0);
    chk("rst_cp",   {24'd0, CP}, 32'd0);
    chk("rst_occ",  {28'd0, Occupancy}, 32'd0);
    cyc();
    chk("rst2_ack", {31'd0, Ack_out}, 32'd0);
    MR      = 1'b0;
    Send_in = 1'b0;
    #1;
    chk("rel_ack",  {31'd0, Ack_out}, 32'd1);
    out_cnt = 0;

    // single packet latency
    Ack_in  = 1'b1;
    Send_in = 1'b1;
    Data_in = 32'hA5A5_0001;
    #1;
    chk("sp_ack", {31'd0, Ack_out}, 32'd1);
    cyc();
    Send_in = 1'b0;
    chk("sp_cp0",  {24'd0, CP}, 32'h01);
    chk("sp_occ0", {28'd0, Occupancy}, 32'd1);
    chk("sp_snd0", {31'd0, Send_out}, 32'd0);
    for (int k = 1; k < 8; k++) begin
      cyc();
      chk("sp_cp",   {24'd0, CP}, 32'd1 << k);
      chk("sp_occ",  {28'd0, Occupancy}, 32'd1);
      chk("sp_send", {31'd0, Send_out}, (k == 7) ? 32'd1 : 32'd0);
    end
    chk("sp_data", Data_out, 32'hA5A5_0001);
    cyc();
    chk("sp_send_end", {31'd0, Send_out}, 32'd0);
    chk("sp_occ_end",  {28'd0, Occupancy}, 32'd0);
    chk("sp_cp_end",   {24'd0, CP}, 32'd0);

    // streaming 100 packets
    Send_in = 1'b1;
    Ack_in  = 1'b1;
    for (int i = 0; i < 100; i++) begin
      Data_in = 32'h0000_0100 + i;
      #1;
      chk("st_ack", {31'd0, Ack_out}, 32'd1);
      if (i >= 8) begin
        chk("st_cp",  {24'd0, CP}, 32'hFF);
        chk("st_occ", {28'd0, Occupancy}, 32'd8);
      end
      cyc();
    end
    Send_in = 1'b0;
    for (int i = 0; i < 8; i++) cyc();
    chk("st_occ_end", {28'd0, Occupancy}, 32'd0);
    chk("st_out_cnt", out_cnt, 32'd101);

    // backpressure to full
    Ack_in  = 1'b0;
    Send_in = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (i < 8) Data_in = 32'h0000_0200 + i;
      #1;
      chk("bp_ack", {31'd0, Ack_out}, (i < 8) ? 32'd1 : 32'd0);
      cyc();
    end
    chk("bp_occ",  {28'd0, Occupancy}, 32'd8);
    chk("bp_send", {31'd0, Send_out}, 32'd1);
    chk("bp_data", Data_out, 32'h0000_0200);
    chk("bp_cp_stall", {24'd0, CP}, 32'd0);
    Ack_in = 1'b1;
    #1;
    chk("bp_sim_ack", {31'd0, Ack_out}, 32'd1);
    cyc();
    Ack_in  = 1'b0;
    Send_in = 1'b0;
    chk("bp_sim_occ",  {28'd0, Occupancy}, 32'd8);
    chk("bp_sim_data", Data_out, 32'h0000_0201);
    chk("bp_sim_cp",   {24'd0, CP}, 32'hFF);
    Ack_in = 1'b1;
    for (int i = 0; i < 8; i++) cyc();
    chk("bp_occ_end", {28'd0, Occupancy}, 32'd0);

    // bubble collapse
    Ack_in = 1'b0;
    for (int p = 1; p <= 3; p++) begin
      Send_in = 1'b1;
      Data_in = p;
      cyc();
      Send_in = 1'b0;
      cyc();
      cyc();
    end
    for (int i = 0; i < 10; i++) cyc();
    chk("bc_occ",  {28'd0, Occupancy}, 32'd3);
    chk("bc_d1",   Data_out, 32'd1);
    Ack_in = 1'b1;
    cyc();
    chk("bc_s2",   {31'd0, Send_out}, 32'd1);
    chk("bc_d2",   Data_out, 32'd2);
    cyc();
    chk("bc_s3",   {31'd0, Send_out}, 32'd1);
    chk("bc_d3",   Data_out, 32'd3);
    cyc();
    chk("bc_empty", {31'd0, Send_out}, 32'd0);

    // reset mid-flight
    Ack_in  = 1'b0;
    Send_in = 1'b1;
    for (int i = 0; i < 5; i++) begin
      Data_in = 32'h0000_0300 + i;
      cyc();
    end
    chk("mf_occ_pre", {28'd0, Occupancy}, 32'd5);
    MR     = 1'b1;
    Ack_in = 1'b1;
    #1;
    chk("mf_ack_mr", {31'd0, Ack_out}, 32'd0);
    cyc();
    MR      = 1'b0;
    Send_in = 1'b0;
    chk("mf_occ",  {28'd0, Occupancy}, 32'd0);
    chk("mf_send", {31'd0, Send_out}, 32'd0);
    chk("mf_cp",   {24'd0, CP}, 32'd0);
    for (int i = 0; i < 20; i++) begin
      cyc();
      chk("mf_no_stale", {31'd0, Send_out}, 32'd0);
      chk("mf_no_under", {28'd0, Occupancy}, 32'd0);
    end

    chk("sb_empty", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
